// File: rtl/apb3_initiator_pkg.sv
// apb3_initiator_pkg
// Shared definitions for the APB3 initiator slice.
//   - state_t : transfer sequencer states (IDLE, SETUP, ACCESS)
//   - DEF_*   : default address/data width and ACCESS-phase timeout limit
//   - rsp_t   : registered response record (read data, error, timeout)
//   - make_rsp: builds an rsp_t from its fields
package apb3_initiator_pkg;

    localparam int DEF_ADDR_W         = 5;
    localparam int DEF_DATA_W         = 8;
    localparam int DEF_TIMEOUT_CYCLES = 255;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] rdata;
        logic                  err;
        logic                  timeout;
    } rsp_t;

    function automatic rsp_t make_rsp(input logic [DEF_DATA_W-1:0] rdata,
                                      input logic                  err,
                                      input logic                  timeout);
        rsp_t r;
        r.rdata   = rdata;
        r.err     = err;
        r.timeout = timeout;
        return r;
    endfunction

endpackage

// File: rtl/apb3_initiator_if.sv
// apb3_initiator_if
// Bundles the command port, the response port and the APB3 bus of the
// initiator.
//   master modport : the initiator (drives cmd_ready, rsp_*, PADDR, PSEL,
//                    PENABLE, PWRITE, PWDATA)
//   slave modport  : the surroundings (local controller plus APB peripheral)
// Parameters ADDR_W / DATA_W size PADDR, cmd_addr and the data buses.
interface apb3_initiator_if
    import apb3_initiator_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;

    logic [ADDR_W-1:0] PADDR;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  rsp_ready,
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output rsp_ready,
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/apb3_initiator_timeout_ctr.sv
// apb_timeout_ctr
// Counts ACCESS-phase wait cycles and flags the cycle on which the limit
// is reached.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : restart the count (asserted while in SETUP)
//   inc        : one more wait cycle (ACCESS with PREADY low)
//   expired    : this inc cycle is wait cycle number LIMIT
module apb_timeout_ctr #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] count_r;

    // Wait-cycle counter; the sequencer leaves ACCESS on expiry so it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            count_r <= {CNT_W{1'b0}};
        end else if (inc) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    // Count holds the waits already seen, so LIMIT-1 plus this one hits the limit.
    assign expired = inc && (count_r == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/apb3_initiator.sv
// apb3_initiator
// Turns valid/ready commands into single APB3 transfers and returns one
// registered response per command.
//   PCLK    : clock, rising edge
//   PRESETN : asynchronous active-low reset
//   bus     : apb3_initiator_if.master (command, response and APB signals)
// Build option: define APB_TIMEOUT_EN to abort an ACCESS phase after
// TIMEOUT_CYCLES wait cycles (response flagged err + timeout). Without it
// ACCESS waits for PREADY indefinitely and rsp_timeout is always 0.
module apb3_initiator
    import apb3_initiator_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic              PCLK,
    input  logic              PRESETN,
    apb3_initiator_if.master  bus
);

    state_t            state_r;
    logic [ADDR_W-1:0] paddr_r;
    logic [DATA_W-1:0] pwdata_r;
    logic              pwrite_r;
    logic              psel_r;
    logic              penable_r;
    logic              cmd_ready_r;
    logic              rsp_valid_r;
    rsp_t              rsp_r;

    logic cmd_fire_s;
    logic rsp_fire_s;
    logic timeout_s;

    assign cmd_fire_s = bus.cmd_valid && cmd_ready_r;
    assign rsp_fire_s = rsp_valid_r && bus.rsp_ready;

`ifdef APB_TIMEOUT_EN
    logic ctr_clear_s;
    logic ctr_inc_s;

    assign ctr_clear_s = (state_r == SETUP);
    assign ctr_inc_s   = (state_r == ACCESS) && !bus.PREADY;

    apb_timeout_ctr #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk     (PCLK),
        .rst_n   (PRESETN),
        .clear   (ctr_clear_s),
        .inc     (ctr_inc_s),
        .expired (timeout_s)
    );
`else
    assign timeout_s = 1'b0;
`endif

    // Transfer sequencer: state, APB drive and response registers.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_r     <= IDLE;
            paddr_r     <= {ADDR_W{1'b0}};
            pwdata_r    <= {DATA_W{1'b0}};
            pwrite_r    <= 1'b0;
            psel_r      <= 1'b0;
            penable_r   <= 1'b0;
            cmd_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_r       <= make_rsp({DEF_DATA_W{1'b0}}, 1'b0, 1'b0);
        end else begin
            case (state_r)
                IDLE: begin
                    // cmd_ready already excludes a pending response, so the
                    // two handshakes never fire together.
                    if (cmd_fire_s) begin
                        state_r     <= SETUP;
                        paddr_r     <= bus.cmd_addr;
                        pwrite_r    <= bus.cmd_write;
                        pwdata_r    <= bus.cmd_wdata;
                        psel_r      <= 1'b1;
                        penable_r   <= 1'b0;
                        cmd_ready_r <= 1'b0;
                    end else if (rsp_fire_s) begin
                        rsp_valid_r <= 1'b0;
                        cmd_ready_r <= 1'b1;
                    end else begin
                        cmd_ready_r <= !rsp_valid_r;
                    end
                end
                SETUP: begin
                    state_r     <= ACCESS;
                    psel_r      <= 1'b1;
                    penable_r   <= 1'b1;
                    cmd_ready_r <= 1'b0;
                end
                ACCESS: begin
                    cmd_ready_r <= 1'b0;
                    // PREADY wins over a timeout landing on the same cycle.
                    if (bus.PREADY) begin
                        state_r     <= IDLE;
                        psel_r      <= 1'b0;
                        penable_r   <= 1'b0;
                        rsp_valid_r <= 1'b1;
                        rsp_r       <= make_rsp(pwrite_r ? {DEF_DATA_W{1'b0}}
                                                         : DEF_DATA_W'(bus.PRDATA),
                                                bus.PSLVERR, 1'b0);
                    end else if (timeout_s) begin
                        state_r     <= IDLE;
                        psel_r      <= 1'b0;
                        penable_r   <= 1'b0;
                        rsp_valid_r <= 1'b1;
                        rsp_r       <= make_rsp({DEF_DATA_W{1'b0}}, 1'b1, 1'b1);
                    end else begin
                        state_r     <= ACCESS;
                        psel_r      <= 1'b1;
                        penable_r   <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    psel_r      <= 1'b0;
                    penable_r   <= 1'b0;
                    cmd_ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready   = cmd_ready_r;
    assign bus.rsp_valid   = rsp_valid_r;
    assign bus.rsp_rdata   = DATA_W'(rsp_r.rdata);
    assign bus.rsp_err     = rsp_r.err;
    assign bus.rsp_timeout = rsp_r.timeout;
    assign bus.PADDR       = paddr_r;
    assign bus.PSEL        = psel_r;
    assign bus.PENABLE     = penable_r;
    assign bus.PWRITE      = pwrite_r;
    assign bus.PWDATA      = pwdata_r;

endmodule

// File: tb/tb_apb3_initiator.sv
// tb_apb3_initiator
// Directed bench for apb3_initiator with a response scoreboard: each issued
// command pushes its expected response, and a monitor pops and compares on
// every rsp_valid && rsp_ready handshake. A scripted APB responder supplies
// PREADY wait states, PRDATA and PSLVERR. Timing checks are made against the
// cycle at which each command was accepted.
module tb_apb3_initiator;
    import apb3_initiator_pkg::*;

    localparam int AW = 5;
    localparam int DW = 8;
    localparam int BIG_WAIT = 32'h7fff_ffff;

    logic PCLK    = 1'b0;
    logic PRESETN = 1'b0;

    apb3_initiator_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    apb3_initiator #(
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .PCLK    (PCLK),
        .PRESETN (PRESETN),
        .bus     (bus)
    );

    always #5 PCLK = ~PCLK;

    int cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    int   total = 0;
    int   bad   = 0;
    rsp_t exp_q[$];

    // responder configuration
    int         waits_cfg  = 0;
    logic [7:0] prdata_cfg = 8'h00;
    logic       err_cfg    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic to_cycle(input int t);
        while (cyc < t) @(negedge PCLK);
    endtask

    // Call at a negedge; returns at the negedge one cycle after acceptance.
    task automatic issue(input logic w, input logic [4:0] a, input logic [7:0] d,
                         input logic push, input rsp_t e, output int n);
        n = -1;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        for (int k = 0; k < 50 && !bus.cmd_ready; k++) @(negedge PCLK);
        if (bus.cmd_ready) begin
            n = cyc;
            if (push) exp_q.push_back(e);
            @(negedge PCLK);
        end else begin
            total++;
            bad++;
            $display("FAIL cmd_accept: cmd_ready got 0 expected 1 (cycle %0d)", cyc);
        end
        bus.cmd_valid = 1'b0;
    endtask

    // APB responder: junk PREADY/PSLVERR outside the completing cycle.
    initial begin : responder
        int acc_cnt;
        acc_cnt     = 0;
        bus.PREADY  = 1'b0;
        bus.PSLVERR = 1'b0;
        bus.PRDATA  = 8'h00;
        forever begin
            @(negedge PCLK);
            if (bus.PSEL && bus.PENABLE) begin
                if (acc_cnt >= waits_cfg) begin
                    bus.PREADY  = 1'b1;
                    bus.PRDATA  = prdata_cfg;
                    bus.PSLVERR = err_cfg;
                end else begin
                    bus.PREADY  = 1'b0;
                    bus.PRDATA  = 8'hA5;
                    bus.PSLVERR = 1'b1;
                end
                acc_cnt++;
            end else begin
                bus.PREADY  = 1'b1;
                bus.PRDATA  = 8'h5C;
                bus.PSLVERR = 1'b1;
                acc_cnt     = 0;
            end
        end
    end

    // Scoreboard monitor.
    initial begin : monitor
        rsp_t e;
        forever begin
            @(negedge PCLK);
            #1;
            if (PRESETN && bus.rsp_valid && bus.rsp_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rsp_unexpected: got a response, expected none (cycle %0d)", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_rdata",   32'(bus.rsp_rdata),   32'(e.rdata));
                    check("rsp_err",     32'(bus.rsp_err),     32'(e.err));
                    check("rsp_timeout", 32'(bus.rsp_timeout), 32'(e.timeout));
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic drain();
        for (int k = 0; k < 30 && exp_q.size() != 0; k++) @(negedge PCLK);
        check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin : stim
        int n;
        int n2;
        int seen;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 5'h00;
        bus.cmd_wdata = 8'h00;
        bus.rsp_ready = 1'b1;

        // reset state
        repeat (2) @(negedge PCLK);
        check("rst_psel",      32'(bus.PSEL),        32'd0);
        check("rst_penable",   32'(bus.PENABLE),     32'd0);
        check("rst_pwrite",    32'(bus.PWRITE),      32'd0);
        check("rst_cmd_ready", 32'(bus.cmd_ready),   32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid),   32'd0);
        check("rst_rsp_flags", 32'({bus.rsp_err, bus.rsp_timeout}), 32'd0);
        check("rst_paddr",     32'(bus.PADDR),       32'd0);
        check("rst_pwdata",    32'(bus.PWDATA),      32'd0);
        check("rst_rsp_rdata", 32'(bus.rsp_rdata),   32'd0);
        PRESETN = 1'b1;
        @(negedge PCLK);
        check("post_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        // 1: zero-wait write
        waits_cfg = 0; prdata_cfg = 8'hEE; err_cfg = 1'b0;
        issue(1'b1, 5'h04, 8'h5A, 1'b1, make_rsp(8'h00, 1'b0, 1'b0), n);
        check("t1_psel_n1",    32'(bus.PSEL),      32'd1);
        check("t1_penable_n1", 32'(bus.PENABLE),   32'd0);
        check("t1_paddr",      32'(bus.PADDR),     32'h04);
        check("t1_pwdata",     32'(bus.PWDATA),    32'h5A);
        check("t1_pwrite",     32'(bus.PWRITE),    32'd1);
        check("t1_cmd_ready",  32'(bus.cmd_ready), 32'd0);
        to_cycle(n + 2);
        check("t1_penable_n2", 32'(bus.PENABLE),   32'd1);
        check("t1_rsp_n2",     32'(bus.rsp_valid), 32'd0);
        to_cycle(n + 3);
        check("t1_rsp_n3",     32'(bus.rsp_valid), 32'd1);
        check("t1_psel_n3",    32'(bus.PSEL),      32'd0);
        check("t1_rdata_n3",   32'(bus.rsp_rdata), 32'h00);
        to_cycle(n + 4);
        check("t1_paddr_hold", 32'(bus.PADDR),     32'h04);
        check("t1_cmd_ready4", 32'(bus.cmd_ready), 32'd1);

        // 2: read with 3 wait states
        waits_cfg = 3; prdata_cfg = 8'hC3; err_cfg = 1'b0;
        issue(1'b0, 5'h11, 8'h00, 1'b1, make_rsp(8'hC3, 1'b0, 1'b0), n);
        for (int c = 1; c <= 5; c++) begin
            to_cycle(n + c);
            check("t2_psel_stable",  32'(bus.PSEL),      32'd1);
            check("t2_paddr_stable", 32'(bus.PADDR),     32'h11);
            check("t2_no_rsp",       32'(bus.rsp_valid), 32'd0);
        end
        to_cycle(n + 6);
        check("t2_rsp_n6",   32'(bus.rsp_valid), 32'd1);
        check("t2_rdata_n6", 32'(bus.rsp_rdata), 32'hC3);
        check("t2_psel_n6",  32'(bus.PSEL),      32'd0);
        @(negedge PCLK);

        // 3: PSLVERR read, response back-pressured for 5 cycles
        bus.rsp_ready = 1'b0;
        waits_cfg = 0; prdata_cfg = 8'h77; err_cfg = 1'b1;
        issue(1'b0, 5'h07, 8'h00, 1'b1, make_rsp(8'h77, 1'b1, 1'b0), n);
        to_cycle(n + 3);
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 5'h1F; bus.cmd_wdata = 8'h33;
        for (int c = 3; c <= 7; c++) begin
            to_cycle(n + c);
            check("t3_rsp_hold",  32'(bus.rsp_valid),   32'd1);
            check("t3_err_hold",  32'(bus.rsp_err),     32'd1);
            check("t3_to_hold",   32'(bus.rsp_timeout), 32'd0);
            check("t3_cmd_ready", 32'(bus.cmd_ready),   32'd0);
            check("t3_no_psel",   32'(bus.PSEL),        32'd0);
        end
        to_cycle(n + 8);
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        to_cycle(n + 9);
        check("t3_rsp_cleared", 32'(bus.rsp_valid), 32'd0);
        check("t3_cmd_ready9",  32'(bus.cmd_ready), 32'd1);
        check("t3_paddr_kept",  32'(bus.PADDR),     32'h07);
        err_cfg = 1'b0;

        // 4: back-to-back writes
        waits_cfg = 0;
        issue(1'b1, 5'h0A, 8'h11, 1'b1, make_rsp(8'h00, 1'b0, 1'b0), n);
        issue(1'b1, 5'h0B, 8'h22, 1'b1, make_rsp(8'h00, 1'b0, 1'b0), n2);
        check("t4_interval", 32'(n2 - n), 32'd4);
        check("t4_psel2",    32'(bus.PSEL),    32'd1);
        check("t4_penable2", 32'(bus.PENABLE), 32'd0);
        check("t4_paddr2",   32'(bus.PADDR),   32'h0B);
        check("t4_pwdata2",  32'(bus.PWDATA),  32'h22);
        drain();

        // 5: reset during ACCESS
        waits_cfg = BIG_WAIT;
        issue(1'b0, 5'h15, 8'h00, 1'b0, make_rsp(8'h00, 1'b0, 1'b0), n);
        to_cycle(n + 3);
        check("t5_penable_pre", 32'(bus.PENABLE), 32'd1);
        #2 PRESETN = 1'b0;
        #1;
        check("t5_psel_rst",      32'(bus.PSEL),      32'd0);
        check("t5_penable_rst",   32'(bus.PENABLE),   32'd0);
        check("t5_rsp_valid_rst", 32'(bus.rsp_valid), 32'd0);
        @(negedge PCLK);
        PRESETN = 1'b1;
        waits_cfg = 0;
        @(negedge PCLK);
        check("t5_cmd_ready_rel", 32'(bus.cmd_ready), 32'd1);
        check("t5_psel_rel",      32'(bus.PSEL),      32'd0);

        // 6: PREADY never arrives
        waits_cfg = BIG_WAIT;
`ifdef APB_TIMEOUT_EN
        issue(1'b0, 5'h02, 8'h00, 1'b1, make_rsp(8'h00, 1'b1, 1'b1), n);
        to_cycle(n + 5);
        check("t6_no_rsp_n5",  32'(bus.rsp_valid),   32'd0);
        check("t6_penable_n5", 32'(bus.PENABLE),     32'd1);
        to_cycle(n + 6);
        check("t6_rsp_n6",     32'(bus.rsp_valid),   32'd1);
        check("t6_timeout",    32'(bus.rsp_timeout), 32'd1);
        check("t6_err",        32'(bus.rsp_err),     32'd1);
        check("t6_rdata",      32'(bus.rsp_rdata),   32'h00);
        check("t6_psel",       32'(bus.PSEL),        32'd0);
        waits_cfg = 0;
`else
        issue(1'b0, 5'h02, 8'h00, 1'b0, make_rsp(8'h00, 1'b0, 1'b0), n);
        seen = 0;
        repeat (1000) begin
            @(negedge PCLK);
            if (bus.rsp_valid) seen++;
        end
        check("t6_no_rsp_1000", 32'(seen),        32'd0);
        check("t6_psel_held",   32'(bus.PSEL),    32'd1);
        check("t6_penable_held",32'(bus.PENABLE), 32'd1);
        #2 PRESETN = 1'b0;
        @(negedge PCLK);
        PRESETN = 1'b1;
        waits_cfg = 0;
        @(negedge PCLK);
`endif
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
